// File: rtl/key_debounce_pkg.sv
// Shared types and default parameters for the keypad debouncer with auto-repeat.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_t;

  localparam int          DEF_CODE_W       = 32'd8;
  localparam int          DEF_DB_CYCLES    = 32'd3;
  localparam int          DEF_CNT_W        = 32'd20;
  localparam logic [7:0]  DEF_RESET_CODE   = 8'h0F;
  localparam int          DEF_REPEAT_EN    = 32'd1;
  localparam int          DEF_REPEAT_DELAY = 32'd40;
  localparam int          DEF_REPEAT_RATE  = 32'd10;

endpackage

// File: rtl/key_debounce_rpt_rpt_timer.sv
// Typematic timer: counts cycles while run is high, ticks once after DELAY cycles,
// then every RATE cycles. clear restarts it in the first-repeat phase.
module rpt_timer #(
  parameter int CNT_W = 20,
  parameter int DELAY = 40,
  parameter int RATE  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;
  logic             first_r;
  logic             tick_r;
  logic [CNT_W-1:0] limit_s;
  logic             hit_s;

  // Select the terminal count for the current repeat phase.
  always_comb begin
    limit_s = RATE_LAST;
    if (first_r) begin
      limit_s = DELAY_LAST;
    end else begin
      limit_s = RATE_LAST;
    end
    hit_s = run && (cnt_r == limit_s);
  end

  // Counter, phase flag and registered tick; counter freezes while run is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r   <= CNT_ZERO;
      first_r <= 1'b1;
      tick_r  <= 1'b0;
    end else if (clear) begin
      cnt_r   <= CNT_ZERO;
      first_r <= 1'b1;
      tick_r  <= 1'b0;
    end else if (hit_s) begin
      cnt_r   <= CNT_ZERO;
      first_r <= 1'b0;
      tick_r  <= 1'b1;
    end else if (run) begin
      cnt_r   <= cnt_r + CNT_ONE;
      tick_r  <= 1'b0;
    end else begin
      tick_r  <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/key_debounce_rpt.sv
// Keypad debouncer: confirms press/release after a stable window, holds the
// confirmed code and emits single-cycle press, release and auto-repeat events.
module key_debounce_rpt
  import key_debounce_pkg::*;
#(
  parameter int                CODE_W       = DEF_CODE_W,
  parameter int                DB_CYCLES    = DEF_DB_CYCLES,
  parameter int                CNT_W        = DEF_CNT_W,
  parameter logic [CODE_W-1:0] RESET_CODE   = CODE_W'(DEF_RESET_CODE),
  parameter int                REPEAT_EN    = DEF_REPEAT_EN,
  parameter int                REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int                REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] sig_in,
  input  logic              key_pressed,
  output logic [CODE_W-1:0] code_out,
  output logic              held,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  db_state_t         state_r;
  db_state_t         state_s;
  logic [CODE_W-1:0] cand_r;
  logic [CODE_W-1:0] cand_s;
  logic [CNT_W-1:0]  db_cnt_r;
  logic [CNT_W-1:0]  db_cnt_s;
  logic [CODE_W-1:0] code_r;
  logic [CODE_W-1:0] code_s;
  logic              held_r;
  logic              held_s;
  logic              press_r;
  logic              press_s;
  logic              release_r;
  logic              release_s;
  logic              rpt_clear_s;

  // Next-state, candidate, debounce counter and event decode.
  always_comb begin
    state_s     = state_r;
    cand_s      = cand_r;
    db_cnt_s    = db_cnt_r;
    code_s      = code_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    rpt_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_pressed) begin
          state_s  = DB_PRESS;
          cand_s   = sig_in;
          db_cnt_s = CNT_ZERO;
        end else begin
          state_s  = IDLE;
        end
      end
      DB_PRESS: begin
        if (!key_pressed) begin
          state_s  = IDLE;
          db_cnt_s = CNT_ZERO;
        end else if (sig_in != cand_r) begin
          // A different code restarts the stability window on the new candidate.
          cand_s   = sig_in;
          db_cnt_s = CNT_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          state_s     = HELD;
          code_s      = cand_r;
          press_s     = 1'b1;
          rpt_clear_s = 1'b1;
        end else begin
          db_cnt_s = db_cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_s  = DB_RELEASE;
          db_cnt_s = CNT_ZERO;
        end else begin
          state_s  = HELD;
        end
      end
      DB_RELEASE: begin
        // Bounce back to HELD keeps the repeat timer phase and count intact.
        if (key_pressed) begin
          state_s   = HELD;
        end else if (db_cnt_r == DB_LAST) begin
          state_s   = IDLE;
          release_s = 1'b1;
        end else begin
          db_cnt_s  = db_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s  = IDLE;
        db_cnt_s = CNT_ZERO;
      end
    endcase
    held_s = (state_s == HELD) || (state_s == DB_RELEASE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      cand_r    <= {CODE_W{1'b0}};
      db_cnt_r  <= CNT_ZERO;
      code_r    <= RESET_CODE;
      held_r    <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cand_r    <= cand_s;
      db_cnt_r  <= db_cnt_s;
      code_r    <= code_s;
      held_r    <= held_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      logic rpt_run_s;
      assign rpt_run_s = (state_r == HELD);
      rpt_timer #(
        .CNT_W (CNT_W),
        .DELAY (REPEAT_DELAY),
        .RATE  (REPEAT_RATE)
      ) u_rpt_timer (
        .clk   (clk),
        .reset (reset),
        .run   (rpt_run_s),
        .clear (rpt_clear_s),
        .tick  (repeat_pulse)
      );
    end else begin : g_no_rpt
      assign repeat_pulse = 1'b0;
    end
  endgenerate

  assign code_out      = code_r;
  assign held          = held_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: tb/tb_key_debounce_rpt.sv
// Directed bench for key_debounce_rpt: default instance plus a DB_CYCLES=1,
// REPEAT_EN=0 instance driven by the same inputs.
module tb_key_debounce_rpt;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sig_in;
  logic       key_pressed;

  logic [7:0] code_out;
  logic       held, press_pulse, release_pulse, repeat_pulse;
  logic [7:0] code_out_b;
  logic       held_b, press_pulse_b, release_pulse_b, repeat_pulse_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  key_debounce_rpt dut (
    .clk           (clk),
    .reset         (reset),
    .sig_in        (sig_in),
    .key_pressed   (key_pressed),
    .code_out      (code_out),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  key_debounce_rpt #(
    .DB_CYCLES (1),
    .REPEAT_EN (0)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .sig_in        (sig_in),
    .key_pressed   (key_pressed),
    .code_out      (code_out_b),
    .held          (held_b),
    .press_pulse   (press_pulse_b),
    .release_pulse (release_pulse_b),
    .repeat_pulse  (repeat_pulse_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    key_pressed = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int first_a, first_b;
    reset = 1'b0; key_pressed = 1'b1; sig_in = 8'h42;
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (code_out !== 8'h0F) $display("FAIL reset_code: got %h expected 0f", code_out);
    else n_pass++;
    n_total++;
    if ({held, press_pulse, release_pulse, repeat_pulse} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {held, press_pulse, release_pulse, repeat_pulse});
    else n_pass++;
    reset = 1'b1;
    step();
    first_a = 0; first_b = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (press_pulse && first_a == 0) first_a = i;
      if (press_pulse_b && first_b == 0) first_b = i;
    end
    n_total++;
    if (first_a !== 3) $display("FAIL reset_press_latency: got %0d expected 3", first_a);
    else n_pass++;
    n_total++;
    if (first_b !== 1) $display("FAIL reset_press_latency_db1: got %0d expected 1", first_b);
    else n_pass++;
    n_total++;
    if (code_out !== 8'h42) $display("FAIL reset_press_code: got %h expected 42", code_out);
    else n_pass++;
    idle_cycles(10);
  endtask

  task automatic test_clean_press_release();
    int first_a, first_b, cnt_a;
    key_pressed = 1'b1; sig_in = 8'h81;
    step();
    first_a = 0; first_b = 0; cnt_a = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (press_pulse) begin cnt_a++; if (first_a == 0) first_a = i; end
      if (press_pulse_b && first_b == 0) first_b = i;
    end
    n_total++;
    if (first_a !== 3) $display("FAIL press_latency: got %0d expected 3", first_a);
    else n_pass++;
    n_total++;
    if (cnt_a !== 1) $display("FAIL press_count: got %0d expected 1", cnt_a);
    else n_pass++;
    n_total++;
    if (first_b !== 1) $display("FAIL press_latency_db1: got %0d expected 1", first_b);
    else n_pass++;
    n_total++;
    if ({code_out, held} !== {8'h81, 1'b1}) $display("FAIL press_code_held: got %h/%b expected 81/1", code_out, held);
    else n_pass++;
    key_pressed = 1'b0;
    step();
    first_a = 0; first_b = 0; cnt_a = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (release_pulse) begin cnt_a++; if (first_a == 0) first_a = i; end
      if (release_pulse_b && first_b == 0) first_b = i;
    end
    n_total++;
    if (first_a !== 3) $display("FAIL release_latency: got %0d expected 3", first_a);
    else n_pass++;
    n_total++;
    if (cnt_a !== 1) $display("FAIL release_count: got %0d expected 1", cnt_a);
    else n_pass++;
    n_total++;
    if (first_b !== 1) $display("FAIL release_latency_db1: got %0d expected 1", first_b);
    else n_pass++;
    n_total++;
    if ({code_out, held} !== {8'h81, 1'b0}) $display("FAIL release_code_held: got %h/%b expected 81/0", code_out, held);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [7:0] glitch;
    int first_a, cnt_a, rel_a, low_held;
    pat = 5'b11101;  // applied LSB first: 1,0,1,1,1
    sig_in = 8'h5A;
    first_a = 0; cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      key_pressed = (i < 5) ? pat[i] : 1'b1;
      step();
      if (press_pulse) begin cnt_a++; if (first_a == 0) first_a = i; end
    end
    n_total++;
    if (first_a !== 5) $display("FAIL bounce_press_edge: got %0d expected 5", first_a);
    else n_pass++;
    n_total++;
    if (cnt_a !== 1) $display("FAIL bounce_press_count: got %0d expected 1", cnt_a);
    else n_pass++;
    glitch = 8'b11111010;  // LSB first: 0,1,0,1,1,1,1,1
    rel_a = 0; low_held = 0;
    for (int i = 0; i < 8; i++) begin
      key_pressed = glitch[i];
      step();
      if (release_pulse) rel_a++;
      if (!held) low_held++;
    end
    n_total++;
    if (rel_a !== 0) $display("FAIL glitch_release: got %0d pulses expected 0", rel_a);
    else n_pass++;
    n_total++;
    if (low_held !== 0) $display("FAIL glitch_held: got %0d low cycles expected 0", low_held);
    else n_pass++;
    idle_cycles(10);
  endtask

  task automatic test_code_change();
    int first_a;
    key_pressed = 1'b1;
    first_a = 0;
    for (int i = 0; i < 10; i++) begin
      sig_in = (i < 2) ? 8'h11 : 8'h12;
      step();
      if (press_pulse && first_a == 0) first_a = i;
    end
    n_total++;
    if (first_a !== 5) $display("FAIL code_change_press_edge: got %0d expected 5", first_a);
    else n_pass++;
    n_total++;
    if (code_out !== 8'h12) $display("FAIL code_change_value: got %h expected 12", code_out);
    else n_pass++;
    idle_cycles(10);
  endtask

  task automatic test_repeat();
    int p, n_rpt, n_rpt_b;
    int offs[8];
    for (int k = 0; k < 8; k++) offs[k] = -1;
    p = 0; n_rpt = 0; n_rpt_b = 0;
    key_pressed = 1'b1; sig_in = 8'h55;
    step();
    for (int i = 1; i <= 82; i++) begin
      step();
      if (press_pulse) p = i;
      if (repeat_pulse) begin
        if (n_rpt < 8) offs[n_rpt] = i - p;
        n_rpt++;
      end
      if (repeat_pulse_b) n_rpt_b++;
    end
    n_total++;
    if (p !== 3) $display("FAIL repeat_press_edge: got %0d expected 3", p);
    else n_pass++;
    n_total++;
    if (n_rpt !== 4) $display("FAIL repeat_count: got %0d expected 4", n_rpt);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (offs[k] !== 40 + 10 * k) $display("FAIL repeat_offset_%0d: got %0d expected %0d", k, offs[k], 40 + 10 * k);
      else n_pass++;
    end
    n_total++;
    if (n_rpt_b !== 0) $display("FAIL repeat_disabled: got %0d pulses expected 0", n_rpt_b);
    else n_pass++;
    idle_cycles(10);
  endtask

  task automatic test_reset_mid_release();
    int rel_a;
    key_pressed = 1'b1; sig_in = 8'h33;
    for (int i = 0; i < 6; i++) step();
    key_pressed = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    n_total++;
    if ({held, release_pulse, code_out} !== {1'b0, 1'b0, 8'h0F})
      $display("FAIL mid_release_reset: got %b/%b/%h expected 0/0/0f", held, release_pulse, code_out);
    else n_pass++;
    reset = 1'b1;
    rel_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (release_pulse) rel_a++;
    end
    n_total++;
    if (rel_a !== 0) $display("FAIL mid_release_no_pulse: got %0d expected 0", rel_a);
    else n_pass++;
    n_total++;
    if (held !== 1'b0) $display("FAIL mid_release_idle: held got %b expected 0", held);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; key_pressed = 1'b0; sig_in = 8'h00;
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_code_change();
    test_repeat();
    test_reset_mid_release();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
